// File: rtl/lmc1992_rx.sv
// lmc1992_rx: Microwire receiver for LMC1992 command frames plus the
// master/left/right volume stage for the 8-bit DMA sound samples.
// Frames are deserialised, validated on the rising edge of mw_done and
// decoded into mixer/tone/volume registers. Samples pass through a
// three-stage attenuation pipeline producing 16-bit signed audio.
module lmc1992_rx #(
    parameter int MUTE_STEPS = 48
) (
    input  logic               clk32,
    input  logic               reset,
    input  logic               mw_stb,
    input  logic               mw_clk,
    input  logic               mw_data,
    input  logic               mw_done,
    input  logic               audio_en,
    input  logic [7:0]         audio_l_in,
    input  logic [7:0]         audio_r_in,
    output logic signed [15:0] audio_l,
    output logic signed [15:0] audio_r,
    output logic               audio_valid,
    output logic [5:0]         master_vol,
    output logic [4:0]         left_vol,
    output logic [4:0]         right_vol,
    output logic [3:0]         bass,
    output logic [3:0]         treble,
    output logic [1:0]         mix,
    output logic               frame_err
);

    localparam logic [5:0] LP_MUTE = 6'(MUTE_STEPS);

    // Total attenuation in 2 dB steps: master headroom plus channel headroom.
    function automatic logic [5:0] fn_atten(input logic [5:0] mv, input logic [4:0] cv);
        return (6'd40 - mv) + (6'd20 - {1'b0, cv});
    endfunction

    // Whole 6 dB shifts contained in the step count.
    function automatic logic [4:0] fn_k(input logic [5:0] n);
        logic [5:0] q;
        q = n / 6'd3;
        return q[4:0];
    endfunction

    // Fractional 0/2/4 dB step as a 16-bit mantissa.
    function automatic logic [16:0] fn_mant(input logic [5:0] n);
        logic [5:0] r;
        r = n % 6'd3;
        case (r)
            6'd0:    return 17'd65535;
            6'd1:    return 17'd52057;
            default: return 17'd41350;
        endcase
    endfunction

    // ---------------- Deserialiser ----------------
    logic [10:0] r_shift;
    logic [3:0]  r_cnt;
    logic        r_done_prev;
    logic        r_close;
    logic [10:0] r_frm_bits;
    logic [3:0]  r_frm_cnt;
    logic [10:0] w_shift_next;
    logic [3:0]  w_cnt_next;
    logic        w_close;

    // Next shift/count including any data bit presented this cycle.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_shift_next = r_shift;
        w_cnt_next   = r_cnt;
        if (mw_stb && mw_clk) begin
            w_shift_next = {r_shift[9:0], mw_data};
            if (r_cnt != 4'd15) begin
                w_cnt_next = r_cnt + 4'd1;
            end
        end
    end

    assign w_close = mw_done & ~r_done_prev;

    // Shift in masked bits; on the mw_done edge snapshot the frame and restart.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk32) begin
        if (reset) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            r_done_prev <= 1'b0;
            r_close     <= 1'b0;
            r_frm_bits  <= '0;
            r_frm_cnt   <= '0;
        end else begin
            r_done_prev <= mw_done;
            r_close     <= w_close;
            if (w_close) begin
                r_frm_bits <= w_shift_next;
                r_frm_cnt  <= w_cnt_next;
                r_shift    <= '0;
                r_cnt      <= '0;
            end else begin
                r_shift <= w_shift_next;
                r_cnt   <= w_cnt_next;
            end
        end
    end

    // ---------------- Decode ----------------
    logic       w_frm_ok;
    logic [2:0] w_cmd;
    logic [5:0] w_d;
    logic [3:0] w_tone;
    logic [5:0] w_mvol;
    logic [4:0] w_cvol;

    assign w_frm_ok = (r_frm_cnt == 4'd11) && (r_frm_bits[10:9] == 2'b10);
    assign w_cmd    = r_frm_bits[8:6];
    assign w_d      = r_frm_bits[5:0];
    assign w_tone   = (w_d[3:0] > 4'd12) ? 4'd12 : w_d[3:0];
    assign w_mvol   = (w_d > 6'd40) ? 6'd40 : w_d;
    assign w_cvol   = (w_d[4:0] > 5'd20) ? 5'd20 : w_d[4:0];

    // Apply a validated frame to its register, or pulse frame_err.
    always_ff @(posedge clk32) begin
        if (reset) begin
            master_vol <= 6'd40;
            left_vol   <= 5'd20;
            right_vol  <= 5'd20;
            bass       <= 4'd6;
            treble     <= 4'd6;
            mix        <= 2'd1;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (r_close) begin
                if (w_frm_ok) begin
                    case (w_cmd)
                        3'b000:  mix        <= w_d[1:0];
                        3'b001:  bass       <= w_tone;
                        3'b010:  treble     <= w_tone;
                        3'b011:  master_vol <= w_mvol;
                        3'b100:  right_vol  <= w_cvol;
                        3'b101:  left_vol   <= w_cvol;
                        default: ;
                    endcase
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    // ---------------- Audio pipeline ----------------
    logic [5:0]         w_n_l, w_n_r;
    logic               r_s1_valid, r_s2_valid;
    logic signed [7:0]  r_s1_s_l, r_s1_s_r;
    logic [16:0]        r_s1_m_l, r_s1_m_r;
    logic [4:0]         r_s1_k_l, r_s1_k_r, r_s2_k_l, r_s2_k_r;
    logic               r_s1_mute_l, r_s1_mute_r, r_s2_mute_l, r_s2_mute_r;
    logic signed [24:0] r_s2_p_l, r_s2_p_r;
    logic [4:0]         w_amt_l, w_amt_r;
    logic signed [24:0] w_sh_l, w_sh_r;

    assign w_n_l   = fn_atten(master_vol, left_vol);
    assign w_n_r   = fn_atten(master_vol, right_vol);
    assign w_amt_l = 5'd8 + r_s2_k_l;
    assign w_amt_r = 5'd8 + r_s2_k_r;
    assign w_sh_l  = r_s2_p_l >>> w_amt_l;
    assign w_sh_r  = r_s2_p_r >>> w_amt_r;

    // S1 samples gains, S2 multiplies, S3 shifts/mutes and presents the result.
    always_ff @(posedge clk32) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s1_s_l    <= '0;
            r_s1_s_r    <= '0;
            r_s1_m_l    <= '0;
            r_s1_m_r    <= '0;
            r_s1_k_l    <= '0;
            r_s1_k_r    <= '0;
            r_s1_mute_l <= 1'b0;
            r_s1_mute_r <= 1'b0;
            r_s2_p_l    <= '0;
            r_s2_p_r    <= '0;
            r_s2_k_l    <= '0;
            r_s2_k_r    <= '0;
            r_s2_mute_l <= 1'b0;
            r_s2_mute_r <= 1'b0;
            audio_l     <= '0;
            audio_r     <= '0;
            audio_valid <= 1'b0;
        end else begin
            r_s1_valid  <= audio_en;
            r_s1_s_l    <= audio_l_in ^ 8'h80;
            r_s1_s_r    <= audio_r_in ^ 8'h80;
            r_s1_m_l    <= fn_mant(w_n_l);
            r_s1_m_r    <= fn_mant(w_n_r);
            r_s1_k_l    <= fn_k(w_n_l);
            r_s1_k_r    <= fn_k(w_n_r);
            r_s1_mute_l <= (w_n_l >= LP_MUTE);
            r_s1_mute_r <= (w_n_r >= LP_MUTE);

            r_s2_valid  <= r_s1_valid;
            r_s2_p_l    <= {{17{r_s1_s_l[7]}}, r_s1_s_l} * {8'd0, r_s1_m_l};
            r_s2_p_r    <= {{17{r_s1_s_r[7]}}, r_s1_s_r} * {8'd0, r_s1_m_r};
            r_s2_k_l    <= r_s1_k_l;
            r_s2_k_r    <= r_s1_k_r;
            r_s2_mute_l <= r_s1_mute_l;
            r_s2_mute_r <= r_s1_mute_r;

            audio_valid <= r_s2_valid;
            if (r_s2_valid) begin
                audio_l <= r_s2_mute_l ? 16'sd0 : w_sh_l[15:0];
                audio_r <= r_s2_mute_r ? 16'sd0 : w_sh_r[15:0];
            end
        end
    end

endmodule

// File: tb/tb_lmc1992_rx.sv
// Testbench for lmc1992_rx: directed Microwire frames and audio samples.
// Expected audio is queued when a sample is issued and checked by an
// independent monitor whenever audio_valid is seen.
module tb_lmc1992_rx;

    logic               clk32 = 1'b0;
    logic               reset;
    logic               mw_stb, mw_clk, mw_data, mw_done;
    logic               audio_en;
    logic [7:0]         audio_l_in, audio_r_in;
    logic signed [15:0] audio_l, audio_r;
    logic               audio_valid;
    logic [5:0]         master_vol;
    logic [4:0]         left_vol, right_vol;
    logic [3:0]         bass, treble;
    logic [1:0]         mix;
    logic               frame_err;

    typedef struct {
        logic signed [15:0] l;
        logic signed [15:0] r;
        int                 cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   fe_seen = 0;
    int   fe_exp = 0;

    lmc1992_rx #(.MUTE_STEPS(48)) dut (
        .clk32(clk32), .reset(reset),
        .mw_stb(mw_stb), .mw_clk(mw_clk), .mw_data(mw_data), .mw_done(mw_done),
        .audio_en(audio_en), .audio_l_in(audio_l_in), .audio_r_in(audio_r_in),
        .audio_l(audio_l), .audio_r(audio_r), .audio_valid(audio_valid),
        .master_vol(master_vol), .left_vol(left_vol), .right_vol(right_vol),
        .bass(bass), .treble(treble), .mix(mix), .frame_err(frame_err)
    );

    always #5 clk32 = ~clk32;

    always @(posedge clk32) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expectation per audio_valid pulse.
    always @(negedge clk32) begin : monitor
        exp_t e;
        if (!reset && frame_err) fe_seen++;
        if (!reset && audio_valid) begin
            if (q.size() == 0) begin
                check("unexpected audio_valid", 1, 0);
            end else begin
                e = q.pop_front();
                check("audio_l", audio_l, e.l);
                check("audio_r", audio_r, e.r);
                check("audio latency", cyc - e.cyc, 3);
            end
        end
    end

    task automatic tick;
        @(posedge clk32);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        audio_en = 1'b0; mw_stb = 1'b0; mw_clk = 1'b0; mw_data = 1'b0; mw_done = 1'b0;
        audio_l_in = 8'h80; audio_r_in = 8'h80;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic check_regs(input int m, input int l, input int r,
                              input int b, input int t, input int x);
        check("master_vol", master_vol, m);
        check("left_vol", left_vol, l);
        check("right_vol", right_vol, r);
        check("bass", bass, b);
        check("treble", treble, t);
        check("mix", mix, x);
    endtask

    // Issue one sample (leaves audio_en high so calls can run back-to-back).
    task automatic put_sample(input logic [7:0] li, input logic [7:0] ri,
                              input int el, input int er);
        exp_t e;
        audio_en = 1'b1; audio_l_in = li; audio_r_in = ri;
        e.l = 16'(el); e.r = 16'(er); e.cyc = cyc;
        q.push_back(e);
        tick;
    endtask

    task automatic drain;
        audio_en = 1'b0;
        for (int i = 0; i < 20 && q.size() > 0; i++) tick;
        check("scoreboard drained", q.size(), 0);
        q.delete();
    endtask

    task automatic send_sample(input logic [7:0] li, input logic [7:0] ri,
                               input int el, input int er);
        put_sample(li, ri, el, er);
        drain();
    endtask

    task automatic send_bit(input logic b, input bit gap);
        if (gap) begin
            mw_stb = 1'b1; mw_clk = 1'b0; mw_data = ~b; tick;
        end
        mw_stb = 1'b1; mw_clk = 1'b1; mw_data = b; tick;
        mw_stb = 1'b0; mw_clk = 1'b0; tick;
    endtask

    // Send the low n bits of v MSB first, close with mw_done, check frame_err
    // two cycles after mw_done is first sampled high.
    task automatic send_frame(input logic [11:0] v, input int n, input bit gaps,
                              input bit last_on_done, input int hold, input bit exp_err);
        int last;
        last = last_on_done ? 1 : 0;
        for (int i = n - 1; i >= last; i--) send_bit(v[i], gaps);
        if (last_on_done) begin
            mw_stb = 1'b1; mw_clk = 1'b1; mw_data = v[0];
        end
        mw_done = 1'b1;
        tick;
        mw_stb = 1'b0; mw_clk = 1'b0;
        tick;
        check("frame_err", frame_err, exp_err);
        if (exp_err) fe_exp++;
        for (int i = 2; i < hold; i++) tick;
        mw_done = 1'b0;
        tick;
    endtask

    initial begin
        do_reset();
        check("audio_valid reset", audio_valid, 0);
        check("audio_l reset", audio_l, 0);
        check("audio_r reset", audio_r, 0);
        check("frame_err reset", frame_err, 0);
        check_regs(40, 20, 20, 6, 6, 1);

        send_sample(8'hC0, 8'h80, 16383, 0);

        send_frame(12'b0_10_101_010001, 11, 0, 0, 1, 0);       // left=17
        check_regs(40, 17, 20, 6, 6, 1);
        send_sample(8'hC0, 8'h80, 8191, 0);
        send_sample(8'hC0, 8'hC0, 8191, 16383);

        send_frame(12'b0_10_101_010011, 11, 0, 0, 1, 0);       // left=19
        send_sample(8'hC0, 8'h80, 13014, 0);

        send_frame(12'b0_10_101_010100, 11, 0, 0, 1, 0);       // left=20
        send_sample(8'h00, 8'h00, -32768, -32768);

        send_frame(12'b0_10_011_111111, 11, 0, 0, 1, 0);       // master 63 -> 40
        send_frame(12'b0_10_001_001111, 11, 0, 0, 1, 0);       // bass 15 -> 12
        send_frame(12'b0_10_010_000011, 11, 0, 0, 1, 0);       // treble=3
        send_frame(12'b0_10_000_000010, 11, 0, 0, 1, 0);       // mix=2
        send_frame(12'b0_10_100_000101, 11, 0, 0, 1, 0);       // right=5
        check_regs(40, 20, 5, 12, 3, 2);
        send_frame(12'b0_10_100_011111, 11, 0, 0, 1, 0);       // right 31 -> 20
        check_regs(40, 20, 20, 12, 3, 2);
        send_frame(12'b0_10_100_000101, 11, 0, 0, 1, 0);       // right=5

        send_frame(12'b0_10_011_010000, 11, 0, 0, 1, 0);       // master=16
        check_regs(16, 20, 5, 12, 3, 2);
        send_sample(8'hC0, 8'hC0, 63, 1);

        send_frame(12'b0_10_011_001100, 11, 0, 0, 1, 0);       // master=12
        send_frame(12'b0_10_101_000001, 11, 0, 0, 1, 0);       // left=1
        send_sample(8'h00, 8'h00, -1, -2);                      // n=47 not muted
        send_frame(12'b0_10_101_000000, 11, 0, 0, 1, 0);       // left=0
        send_sample(8'h00, 8'h00, 0, -2);                       // n=48 muted
        check_regs(12, 0, 5, 12, 3, 2);

        send_frame(12'b00_10_101_01000, 10, 0, 0, 1, 1);       // 10-bit frame
        check_regs(12, 0, 5, 12, 3, 2);
        send_frame(12'b1_10_101_010001, 12, 0, 0, 1, 1);       // 12-bit frame
        check_regs(12, 0, 5, 12, 3, 2);
        send_frame(12'b0_01_101_010101, 11, 0, 0, 1, 1);       // bad address
        check_regs(12, 0, 5, 12, 3, 2);
        send_frame(12'b0_10_110_000001, 11, 0, 0, 1, 0);       // cmd 11x ignored
        check_regs(12, 0, 5, 12, 3, 2);

        send_frame(12'b0_10_000_000011, 11, 1, 0, 1, 0);       // mix=3, masked gaps
        check_regs(12, 0, 5, 12, 3, 3);
        send_frame(12'b0_10_010_001010, 11, 0, 1, 1, 0);       // treble=10, last bit on edge
        check_regs(12, 0, 5, 12, 10, 3);
        send_frame(12'b00_10_101_01000, 10, 0, 0, 4, 1);       // mw_done held 4 cycles
        check_regs(12, 0, 5, 12, 10, 3);

        // Sample in flight when reset arrives must be dropped.
        audio_en = 1'b1; audio_l_in = 8'h00; audio_r_in = 8'h00;
        tick;
        audio_en = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) tick;
        check("audio_l after reset", audio_l, 0);
        check("audio_r after reset", audio_r, 0);
        check_regs(40, 20, 20, 6, 6, 1);

        // Partial frame lost to reset, then a clean frame.
        for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
        do_reset();
        send_frame(12'b0_10_100_001010, 11, 0, 0, 1, 0);       // right=10
        check_regs(40, 20, 10, 6, 6, 1);

        // Back-to-back samples, one per cycle.
        put_sample(8'hC0, 8'hC0, 16383, 1626);
        put_sample(8'h00, 8'h00, -32768, -3254);
        put_sample(8'h40, 8'h40, -16384, -1627);
        drain();

        for (int i = 0; i < 4; i++) tick;
        check("frame_err pulse count", fe_seen, fe_exp);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lmc1992_rx.md
# lmc1992_rx

Microwire receiver and volume stage for the STE audio path. It is the far end of the Microwire link driven by the DMA-sound register block. It deserialises the masked 11-bit LMC1992 command frames, decodes them into mixer, tone and volume registers, and applies master plus left/right attenuation to the 8-bit DMA sound samples. The result is 16-bit signed audio for the downstream mixer/DAC.

## Interface
- MUTE_STEPS, 48: total attenuation step count (2 dB each) at or above which output is forced to 0.

- clk32  in  1  32 MHz system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- mw_stb  in  1  one-cycle strobe per Microwire bit slot; mw_clk/mw_data valid on this cycle.
- mw_clk  in  1  mask bit for the current slot; 1 = slot carries a data bit.
- mw_data  in  1  serial data bit, MSB first.
- mw_done  in  1  end-of-transfer indication (level); its rising edge closes the frame.
- audio_en  in  1  sample strobe (one cycle per output sample).
- audio_l_in, audio_r_in  in  8  offset-binary samples (0x80 = silence).
- audio_l, audio_r  out  16  signed attenuated samples.
- audio_valid  out  1  one-cycle pulse when audio_l/audio_r update.
- master_vol  out  6  0..40 (-80..0 dB).
- left_vol, right_vol  out  5  0..20 (-40..0 dB).
- bass, treble  out  4  0..12 (6 = flat).
- mix  out  2  mixer select, raw.
- frame_err  out  1  one-cycle pulse on a rejected frame.

## Operation
- Reset values:
  - master_vol=40, left_vol=right_vol=20, bass=treble=6, mix=1.
  - audio_l=audio_r=0, audio_valid=0, frame_err=0.
  - Shift register and bit count cleared.
- Deserialiser:
  - Each clk32 cycle with mw_stb=1 and mw_clk=1 shifts mw_data into an 11-bit register (shift left, new bit at LSB).
  - The 4-bit count increments and saturates at 15.
  - mw_stb with mw_clk=0 is ignored.
- Frame close: rising edge of mw_done (registered compare, prev=0, now=1).
  - If mw_stb arrives on the same cycle as the edge, that bit is shifted in first and is counted in the frame.
  - Valid frame: count==11 and bits[10:9]==2'b10. It is decoded as cmd=bits[8:6], d=bits[5:0].
  - Otherwise the frame is discarded and frame_err pulses.
  - In both cases count clears after close.
- Decode:
  - 000: mix<=d[1:0].
  - 001: bass<=min(d[3:0],12).
  - 010: treble<=min(d[3:0],12).
  - 011: master_vol<=min(d,40).
  - 100: right_vol<=min(d[4:0],20).
  - 101: left_vol<=min(d[4:0],20).
  - 11x: no effect and no error.
  - Clamping applies to out-of-range values.
- Audio pipeline (per channel; L uses left_vol, R uses right_vol):
  - S1 (audio_en): s = in ^ 0x80 as signed 8-bit; n = (40-master_vol)+(ch_vol) complement, i.e. n = (40-master_vol)+(20-ch_vol), range 0..60; k = n/3; m = mantissa[n%3] with {65535, 52057, 41350}.
  - S2: p = s × m, signed 25-bit.
  - S3: out = (p >>> (8+k)) truncated to 16 bits; out = 0 if n ≥ MUTE_STEPS. audio_valid pulses.
- Gains are sampled in S1: register writes affect the next audio_en, never a sample in flight.
- bass/treble/mix are stored and exported only; there is no filtering in this block.

## Timing
- Register update: a decoded register is visible on its output port 2 cycles after the cycle in which mw_done is first seen high.
- frame_err asserts in that same cycle.
- Audio latency: audio_valid is high exactly 3 cycles after audio_en, and outputs hold until the next update.
- audio_en back-to-back on every cycle must be accepted: the pipeline is fully pipelined, one sample per cycle.
- Reset mid-frame discards partial bits.
- Reset mid-pipeline drops in-flight samples, with no audio_valid pulse for them.
- mw_done held high across multiple cycles closes exactly one frame.

## Test plan
- Reset, then audio_en with L=0xC0, R=0x80 -> 3 cycles later audio_l=16383, audio_r=0, audio_valid for 1 cycle.
- Frame 11'b10_101_010001 (left=17), then L=0xC0 -> audio_l=8191; audio_r unchanged path gives 0 for 0x80.
- Frame left=19 (n=1), L=0xC0 -> audio_l=13014; L=0x00 at left=20 -> audio_l=-32768.
- Frame 11'b10_011_111111 -> master_vol=40 (clamped); frame master=16 (n=24, k=8) with L=0xC0 -> audio_l=63.
- 10-bit frame, 12-bit frame, and address 2'b01 -> frame_err pulse each; all registers unchanged.
- mw_stb with mw_clk=0 interleaved in a valid frame -> ignored bits skipped and frame accepted. mw_stb on the mw_done edge cycle -> counted. Reset after 5 bits, then an 11-bit frame -> accepted.
